// File: rtl/pwm_capture.sv
// PWM receiver: synchronises an external PWM line, measures period and high time per frame,
// and recovers the 8-bit duty code of the matching generator (high = duty*4+1 in a 1024 frame).
module pwm_capture #(
    parameter int PERIOD     = 1024,
    parameter int PERIOD_TOL = 4,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             pwm_in,
    output logic [7:0]       duty_cycle,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             period_err,
    output logic             stuck
);

    localparam int               SHIFT       = $clog2(PERIOD) - 8;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   LO_LIM      = (CNT_W+1)'(PERIOD - PERIOD_TOL);
    localparam logic [CNT_W:0]   HI_LIM      = (CNT_W+1)'(PERIOD + PERIOD_TOL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_STUCK
    } state_t;

    state_t           state, next_state;
    logic             s_meta, s, s_d;
    logic             rise;
    logic [CNT_W-1:0] period_cnt, high_cnt;
    logic             timeout_hit;
    logic             capture, go_stuck;
    logic             in_tol;
    logic [CNT_W-1:0] high_m1, scaled;
    logic [7:0]       duty_calc;

    // NOTE: every flop below uses non-blocking assignment so each stage samples the old value of the previous one.
    always_ff @(posedge clk) begin
        if (arst) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            s_meta <= pwm_in;
            s      <= s_meta;
            s_d    <= s;
        end
    end

    assign rise = s & ~s_d;

    // The rise cycle itself counts as the first clock of the new frame and of its high phase.
    always_ff @(posedge clk) begin
        if (arst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
        end else begin
            if (period_cnt != CNT_MAX)
                period_cnt <= period_cnt + CNT_ONE;
            if (s && (high_cnt != CNT_MAX))
                high_cnt <= high_cnt + CNT_ONE;
        end
    end

    assign timeout_hit = !rise && (period_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (arst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // NOTE: all outputs of this block get a default first so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        go_stuck   = 1'b0;
        case (state)
            ST_IDLE, ST_STUCK: begin
                if (rise) begin
                    next_state = ST_ARMED;
                end else if (timeout_hit) begin
                    next_state = ST_STUCK;
                    go_stuck   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    next_state = ST_STUCK;
                    go_stuck   = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign in_tol    = ({1'b0, period_cnt} >= LO_LIM) && ({1'b0, period_cnt} <= HI_LIM);
    assign high_m1   = (high_cnt == '0) ? '0 : high_cnt - CNT_ONE;
    assign scaled    = high_m1 >> SHIFT;
    assign duty_calc = (|scaled[CNT_W-1:8]) ? 8'hFF : scaled[7:0];

    always_ff @(posedge clk) begin
        if (arst) begin
            duty_cycle <= '0;
            period     <= '0;
            high_time  <= '0;
            valid      <= 1'b0;
            period_err <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (capture) begin
                period     <= period_cnt;
                high_time  <= high_cnt;
                valid      <= 1'b1;
                period_err <= !in_tol;
                if (in_tol)
                    duty_cycle <= duty_calc;
            end else if (go_stuck) begin
                duty_cycle <= s ? 8'hFF : 8'h00;
                period_err <= 1'b0;
            end
        end
    end

    assign stuck = (state == ST_STUCK);

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the motor PWM generator: samples an incoming PWM waveform, measures its period and high time, and recovers the 8-bit duty_cycle code that produced it.
- Used to read back the drive PWM for closed-loop checking, and to decode PWM commands arriving from an external controller.
- Exact inverse of the generator convention: high time = duty*4+1 clocks in a 1024-clock frame.

Parameters:
- PERIOD, 1024, nominal frame length in clocks; must be a power of two, 256 or more.
- PERIOD_TOL, 4, allowed |measured period - PERIOD| in clocks before period_err is raised.
- CNT_W, 16, width of the period and high-time counters.
- TIMEOUT, 4096, clocks without a rising edge before the input is declared stuck; must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock.
- arst  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- duty_cycle  out  8  recovered duty code.
- period  out  CNT_W  last measured frame length in clocks.
- high_time  out  CNT_W  last measured high time in clocks.
- valid  out  1  one-cycle pulse when a frame measurement is published.
- period_err  out  1  last frame length was out of tolerance.
- stuck  out  1  input has had no rising edge for TIMEOUT clocks.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (arst, sampled on posedge clk). While arst=1:
  - all outputs go to 0;
  - synchroniser flops and counters are cleared;
  - the armed flag is cleared.
- Synchroniser and edge detect:
  - pwm_in passes through a 2-flop synchroniser to give s; a third flop holds s_d.
  - rise = s & ~s_d. Input-to-rise latency is 3 clocks.
- Counters:
  - On a rise cycle: period_cnt <= 1 and high_cnt <= 1.
  - Otherwise: period_cnt increments every cycle, and high_cnt increments only while s=1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Capture, on a rise cycle while armed=1, using the pre-reset counter values:
  - period <= period_cnt; high_time <= high_cnt.
  - valid pulses in the next cycle, together with updated outputs.
  - If |period_cnt - PERIOD| <= PERIOD_TOL:
    - period_err <= 0;
    - duty_cycle <= min(255, (high_cnt-1) >> (log2(PERIOD)-8)).
  - Else: period_err <= 1 and duty_cycle holds its previous value.
- First rise after reset or after stuck: sets armed=1 and clears stuck. No capture and no valid pulse.
- Timeout, when period_cnt reaches TIMEOUT with no rise:
  - stuck <= 1 and armed <= 0;
  - duty_cycle <= 255 if s=1, else 0;
  - period and high_time hold; valid does not pulse; period_err <= 0.
  - stuck stays set until the next rise.
- Simultaneous events:
  - A rise in the same cycle as the timeout threshold is treated as a rise; the timeout is ignored.
  - arst overrides everything.
- Reset mid-frame: the partial frame is discarded and the next rise only re-arms.
- A high-time count above the 255 code (equality handled by min) saturates duty_cycle at 255.

Test Plan:
- Generator-shaped input with 1024-clock frames, high for 4*d+1 clocks, for d = 0, 1, 128, 255 -> from the second rise on: duty_cycle=d, period=1024, high_time=4d+1, period_err=0, one valid per frame.
- First frame after arst release -> no valid pulse until the second rise; all outputs 0 until then.
- Frame length 1030, high 513 clocks -> valid pulses, period=1030, period_err=1, duty_cycle keeps the prior value. Next 1024 frame -> period_err=0 and duty updates to 128.
- pwm_in held at 1 after a valid frame -> stuck=1 at TIMEOUT=4096 clocks after the last rise, duty_cycle=255. Held at 0 instead -> duty_cycle=0. Next rise clears stuck, no valid; the following rise produces a valid pulse.
- arst asserted for 1 cycle mid-frame with duty 64 -> all outputs 0 the next cycle. Valid resumes with duty 64 at the second rise after release.
- Single-cycle glitch low inside the high phase -> extra rise seen, short period flagged with period_err=1, duty_cycle unchanged.
